// File: rtl/router_fifo_if.sv
// rtl/router_fifo_if.sv - router FIFO handshake bundle; overflow present under ROUTER_FIFO_OVF_FLAG_EN
interface router_fifo_if;
    logic       soft_reset;
    logic       write_enb;
    logic       read_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       pkt_busy;
    logic       full;
    logic       empty;
`ifdef ROUTER_FIFO_OVF_FLAG_EN
    logic       overflow;

    modport master (
        output soft_reset, write_enb, read_enb, lfd_state, data_in,
        input  data_out, data_valid, pkt_busy, full, empty, overflow
    );
    modport slave (
        input  soft_reset, write_enb, read_enb, lfd_state, data_in,
        output data_out, data_valid, pkt_busy, full, empty, overflow
    );
`else
    modport master (
        output soft_reset, write_enb, read_enb, lfd_state, data_in,
        input  data_out, data_valid, pkt_busy, full, empty
    );
    modport slave (
        input  soft_reset, write_enb, read_enb, lfd_state, data_in,
        output data_out, data_valid, pkt_busy, full, empty
    );
`endif
endinterface

// File: rtl/router_fifo.sv
// rtl/router_fifo.sv - 16x9 packet FIFO with header-driven busy counter; overflow flag via ROUTER_FIFO_OVF_FLAG_EN
module router_fifo (
    input  logic         clk,
    input  logic         reset,
    router_fifo_if.slave bus
);
    logic [8:0] mem [16];

    logic [4:0] wr_ptr_q, wr_ptr_d;
    logic [4:0] rd_ptr_q, rd_ptr_d;
    logic [6:0] cnt_q, cnt_d;
    logic [7:0] dout_q, dout_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic       full, empty;
    logic       do_wr, do_rd;
    logic [8:0] rd_entry;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[3:0] == rd_ptr_q[3:0]) && (wr_ptr_q[4] != rd_ptr_q[4]);
    assign do_wr    = bus.write_enb && !full && !bus.soft_reset;
    assign do_rd    = bus.read_enb && !empty;
    assign rd_entry = mem[rd_ptr_q[3:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        valid_d  = 1'b0;
        if (bus.soft_reset) begin
            wr_ptr_d = 5'd0;
            rd_ptr_d = 5'd0;
            cnt_d    = 7'd0;
            dout_d   = 8'h00;
        end else begin
            if (do_wr) wr_ptr_d = wr_ptr_q + 5'd1;
            if (do_rd) begin
                rd_ptr_d = rd_ptr_q + 5'd1;
                dout_d   = rd_entry[7:0];
                valid_d  = 1'b1;
                // Header length field counts payload bytes; +1 covers the trailing parity byte.
                if (rd_entry[8])
                    cnt_d = {1'b0, rd_entry[7:2]} + 7'd1;
                else if (cnt_q != 7'd0)
                    cnt_d = cnt_q - 7'd1;
            end
        end
        busy_d = (cnt_d != 7'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= 5'd0;
            rd_ptr_q <= 5'd0;
            cnt_q    <= 7'd0;
            dout_q   <= 8'h00;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    // Storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q[3:0]] <= {bus.lfd_state, bus.data_in};
    end

`ifdef ROUTER_FIFO_OVF_FLAG_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q | (bus.write_enb & full);
        if (bus.soft_reset) ovf_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ovf_q <= 1'b0;
        else       ovf_q <= ovf_d;
    end

    assign bus.overflow = ovf_q;
`endif

    assign bus.data_out   = dout_q;
    assign bus.data_valid = valid_q;
    assign bus.pkt_busy   = busy_q;
    assign bus.full       = full;
    assign bus.empty      = empty;
endmodule

// File: tb/tb_router_fifo.sv
// tb/tb_router_fifo.sv - scoreboard bench for router_fifo against a queue-based reference model
module tb_router_fifo;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    router_fifo_if bus();
    router_fifo dut (.clk(clk), .reset(reset), .bus(bus));

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [8:0] mq[$];
    logic [7:0] exp_q[$];
    int         m_cnt;
    logic       m_valid;
    logic [7:0] m_dout;
    logic       m_ovf;
    bit         mon_en = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        exp_q.delete();
        m_cnt   = 0;
        m_valid = 0;
        m_dout  = 8'h00;
        m_ovf   = 0;
    endtask

    // Model is evaluated on pre-edge occupancy, then one clock edge is taken.
    task automatic cycle(bit we, bit re, bit lfd, logic [7:0] din, bit sr);
        int         occ;
        logic [8:0] e;
        occ = mq.size();
        bus.write_enb  = we;
        bus.read_enb   = re;
        bus.lfd_state  = lfd;
        bus.data_in    = din;
        bus.soft_reset = sr;
        m_valid = 0;
        if (sr) begin
            mq.delete();
            m_cnt  = 0;
            m_dout = 8'h00;
            m_ovf  = 0;
        end else begin
            if (we && occ == 16) m_ovf = 1;
            if (re && occ > 0) begin
                e = mq.pop_front();
                exp_q.push_back(e[7:0]);
                m_dout  = e[7:0];
                m_valid = 1;
                if (e[8]) m_cnt = int'(e[7:2]) + 1;
                else if (m_cnt > 0) m_cnt--;
            end
            if (we && occ < 16) mq.push_back({lfd, din});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #2;
        if (mon_en) begin
            chk("data_valid", bus.data_valid, m_valid);
            chk("data_out_hold", bus.data_out, m_dout);
            if (bus.data_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL pop_data: got unexpected %0h, want no pop", bus.data_out);
                end else begin
                    chk("pop_data", bus.data_out, exp_q.pop_front());
                end
            end
            chk("empty", bus.empty, mq.size() == 0);
            chk("full", bus.full, mq.size() == 16);
            chk("pkt_busy", bus.pkt_busy, m_cnt != 0);
`ifdef ROUTER_FIFO_OVF_FLAG_EN
            chk("overflow", bus.overflow, m_ovf);
`endif
        end
    end

    task automatic check_cleared(string tag);
        chk({tag, "_data_out"}, bus.data_out, 8'h00);
        chk({tag, "_data_valid"}, bus.data_valid, 1'b0);
        chk({tag, "_pkt_busy"}, bus.pkt_busy, 1'b0);
        chk({tag, "_empty"}, bus.empty, 1'b1);
        chk({tag, "_full"}, bus.full, 1'b0);
`ifdef ROUTER_FIFO_OVF_FLAG_EN
        chk({tag, "_overflow"}, bus.overflow, 1'b0);
`endif
    endtask

    initial begin
        logic [7:0] b;
        reset          = 1'b1;
        bus.soft_reset = 1'b0;
        bus.write_enb  = 1'b0;
        bus.read_enb   = 1'b0;
        bus.lfd_state  = 1'b0;
        bus.data_in    = 8'h00;
        model_clear();
        #12;
        check_cleared("reset");
        @(negedge clk);
        reset  = 1'b0;
        mon_en = 1;

        // Header 0x0C announces 3 payload bytes plus parity.
        cycle(1, 0, 1, 8'h0C, 0);
        cycle(1, 0, 0, 8'hB1, 0);
        cycle(1, 0, 0, 8'hB2, 0);
        cycle(1, 0, 0, 8'hB3, 0);
        cycle(1, 0, 0, 8'h5E, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 8'h00, 0);
        cycle(0, 0, 0, 8'h00, 0);

        // Fill to full, overflow attempt, read+write at full, then drain.
        for (int i = 0; i < 16; i++) cycle(1, 0, 0, 8'($urandom), 0);
        cycle(1, 0, 0, 8'hAA, 0);
        cycle(1, 1, 0, 8'hAB, 0);
        cycle(1, 0, 0, 8'h3C, 0);
        for (int i = 0; i < 16; i++) cycle(0, 1, 0, 8'h00, 0);

        // Simultaneous read/write at occupancy 8.
        for (int i = 0; i < 8; i++) cycle(1, 0, 0, 8'(8'h40 + i), 0);
        for (int i = 0; i < 4; i++) cycle(1, 1, 0, 8'(8'h80 + i), 0);

        // Soft reset with a read pending overrides the read.
        cycle(0, 1, 1, 8'h14, 0);
        cycle(1, 1, 0, 8'h00, 1);
        cycle(0, 0, 0, 8'h00, 0);

        // Asynchronous reset mid-packet.
        cycle(1, 0, 1, 8'h10, 0);
        cycle(1, 0, 0, 8'h21, 0);
        cycle(1, 0, 0, 8'h22, 0);
        cycle(0, 1, 0, 8'h00, 0);
        #1 reset = 1'b1;
        #1;
        check_cleared("async_reset");
        model_clear();
        bus.write_enb = 1'b0;
        bus.read_enb  = 1'b0;
        #1 reset = 1'b0;
        cycle(1, 0, 0, 8'h55, 0);
        cycle(0, 1, 0, 8'h00, 0);
        cycle(0, 0, 0, 8'h00, 0);

        // Pointer wrap with an incrementing pattern.
        for (int i = 0; i < 40; i++) begin
            cycle(1, 0, 0, 8'(i), 0);
            cycle(0, 1, 0, 8'h00, 0);
        end

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            b = 8'($urandom);
            cycle($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
                  $urandom_range(0, 99) < 15, b, $urandom_range(0, 99) < 3);
        end

        for (int i = 0; i < 20 && mq.size() > 0; i++) cycle(0, 1, 0, 8'h00, 0);
        cycle(0, 0, 0, 8'h00, 0);
        chk("scoreboard_drain", exp_q.size(), 0);
        mon_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/router_fifo.md
ROUTER_FIFO -- requirements
Module: router_fifo

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the ports SHALL be as follows, clock and reset first.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 soft_reset  input  1  synchronous flush; high means the destination timed out.
REQ-005 write_enb  input  1  write request from the destination-select logic.
REQ-006 read_enb  input  1  read request from the destination port.
REQ-007 lfd_state  input  1  the byte on data_in is a header; it is stored as tag bit 8.
REQ-008 data_in  input  8  byte from the register stage (its dout).
REQ-009 data_out  output  8  registered read data.
REQ-010 data_valid  output  1  data_out holds a byte popped on the previous edge.
REQ-011 pkt_busy  output  1  the remaining-byte counter is non-zero.
REQ-012 full  output  1  16 entries stored.
REQ-013 empty  output  1  0 entries stored.

Function
REQ-014 Storage SHALL be 16 entries x 9 bits, each entry {lfd_state, data_in}.
REQ-015 Read and write pointers SHALL be 5 bits (4 address + 1 wrap); empty = pointers equal; full = address bits equal and wrap bits differ; both combinational from the pointers.
REQ-016 A write SHALL occur on an edge with write_enb=1 and full=0: store entry, increment wr_ptr mod 32; write_enb while full SHALL be dropped with no state change.
REQ-017 A read SHALL occur on an edge with read_enb=1 and empty=0: data_out <= entry[7:0], data_valid <= 1, increment rd_ptr mod 32; otherwise data_valid <= 0 and data_out holds.
REQ-018 A simultaneous read and write SHALL both take effect in the same edge; occupancy stays unchanged; full/empty gating uses pre-edge flags, so write-at-full is dropped even when a read occurs.
REQ-019 Read latency SHALL be 1 cycle (read edge -> data_out/data_valid); write-to-empty-deassert latency SHALL be 1 cycle; no bypass path.
REQ-020 Popping an entry with tag=1 SHALL load the 7-bit counter with entry[7:2] + 1 (payload length plus parity byte).
REQ-021 Popping an entry with tag=0 while the counter is non-zero SHALL decrement the counter by 1; the counter SHALL never wrap below 0.
REQ-022 pkt_busy SHALL equal (counter != 0), registered.
REQ-023 soft_reset=1 at an edge SHALL clear the pointers, counter, data_out, data_valid and (if compiled) overflow; it SHALL override a same-cycle read/write.
REQ-024 Memory contents need not be cleared by either reset; the pointers define validity.

Reset
REQ-025 On reset=1, asynchronously: pointers=0, counter=0, data_out=8'h00, data_valid=0, pkt_busy=0, so empty=1 and full=0.
REQ-026 A reset asserted mid-packet SHALL abandon the packet; after release, the first write SHALL be readable normally.

Configuration
REQ-027 Macro ROUTER_FIFO_OVF_FLAG_EN: when defined, the block SHALL add output overflow (1 bit), a sticky flag set on any edge with write_enb=1 and full=1, cleared by reset or soft_reset.
REQ-028 Without ROUTER_FIFO_OVF_FLAG_EN, the overflow port and logic SHALL be absent; all other behaviour is identical.

Verification
REQ-029 Write header 8'h0C (lfd=1) + 3 payload bytes + parity, then read 5 times -> data_out 0C, b1, b2, b3, parity; pkt_busy high from the edge after the header pop until the parity pop; empty=1 at the end.
REQ-030 Write 16 bytes -> full=1 after the 16th edge; 17th write of 8'hAA dropped; 16 reads return the original order; with the macro, overflow=1 and stays high.
REQ-031 At full, assert read_enb and write_enb together -> read occurs, write dropped, full deasserts; at 8 entries with both -> occupancy stays 8.
REQ-032 Load 5 entries, pulse soft_reset with read_enb=1 -> empty=1, data_valid=0, data_out=00, pkt_busy=0 on that edge.
REQ-033 Assert reset asynchronously between edges mid-packet -> outputs clear immediately; after release, write 8'h55 then read -> data_out=55 one cycle after the read edge.
REQ-034 Wrap test: 40 write/read pairs of an incrementing pattern -> the pointers wrap past 31 with no data corruption and no false full/empty.
